g_bitwise_acc: RTL and testbench

- Parametrised, sequential successor to the fixed 16-bit bitwise gate.
- Applies a selectable bitwise operation (AND, OR, XOR, NAND) across a frame of WIDTH-bit words arriving on a valid/ready stream.
- Returns one reduced word per frame, plus a beat count and a zero flag.
- Sits between a word source (RAM scan, test harness) and the ALU/CPU datapath as a multi-operand logic reducer.

---
 rtl/g_bitwise_acc.sv | 97 +++++++++
 tb/tb_g_bitwise_acc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/g_bitwise_acc.sv
// g_bitwise_acc: multi-operand bitwise reducer (AND/OR/XOR/NAND) over a
// valid/ready framed word stream; one reduced word, beat count and zero flag
// per frame.
module g_bitwise_acc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic             beat;

  assign beat = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DONE : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, latched op and saturating beat counter.
  // NAND accumulates as AND; the inversion is applied once on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      op_r <= '0;
      cnt  <= '0;
    end else if (beat) begin
      if (state == IDLE) begin
        acc  <= in_data;
        op_r <= op;
        cnt  <= CNT_W'(1);
      end else begin
        case (op_r)
          2'd1:    acc <= acc | in_data;
          2'd2:    acc <= acc ^ in_data;
          default: acc <= acc & in_data;
        endcase
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result view, derived purely from registers so it holds under backpressure.
  always_comb begin
    out_data  = (op_r == 2'd3) ? ~acc : acc;
    out_count = cnt;
    out_zero  = ~|out_data;
  end

endmodule

// File: tb/tb_g_bitwise_acc.sv
// Testbench for g_bitwise_acc: directed and random frames checked against a
// reduction model, on a default instance and a CNT_W=2 instance fed in lockstep.
module tb_g_bitwise_acc;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    op;
  logic          in_valid, in_last, out_ready;
  logic [W-1:0]  in_data;

  logic          in_ready_a, out_valid_a, out_zero_a;
  logic [W-1:0]  out_data_a;
  logic [7:0]    out_count_a;
  logic          in_ready_b, out_valid_b, out_zero_b;
  logic [W-1:0]  out_data_b;
  logic [1:0]    out_count_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] words [16];

  always #5 clk = ~clk;

  g_bitwise_acc #(.WIDTH(W), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .op(op),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_count(out_count_a), .out_zero(out_zero_a)
  );

  g_bitwise_acc #(.WIDTH(W), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .op(op),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_count(out_count_b), .out_zero(out_zero_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reduction of the whole frame by the chosen operation's identity element.
  function automatic logic [W-1:0] ref_result(input int n, input logic [1:0] f);
    logic [W-1:0] r;
    r = (f == 2'd0 || f == 2'd3) ? {W{1'b1}} : {W{1'b0}};
    for (int i = 0; i < n; i++) begin
      case (f)
        2'd1:    r = r | words[i];
        2'd2:    r = r ^ words[i];
        default: r = r & words[i];
      endcase
    end
    return (f == 2'd3) ? ~r : r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input logic [1:0] f, input int bp, input bit gaps);
    logic [W-1:0] exp_d;
    int exp_a, exp_b;
    exp_d = ref_result(n, f);
    exp_a = (n > 255) ? 255 : n;
    exp_b = (n > 3) ? 3 : n;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = W'($urandom);
        op       = 2'($urandom);
        tick();
        check("gap_no_out", {31'd0, out_valid_a}, 32'd0);
      end
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = (i == n - 1);
      op       = (i == 0) ? f : 2'($urandom);
      check("in_ready_a", {31'd0, in_ready_a}, 32'd1);
      check("in_ready_b", {31'd0, in_ready_b}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("out_valid_a", {31'd0, out_valid_a}, 32'd1);
    check("out_valid_b", {31'd0, out_valid_b}, 32'd1);
    check("out_data_a", {16'd0, out_data_a}, {16'd0, exp_d});
    check("out_data_b", {16'd0, out_data_b}, {16'd0, exp_d});
    check("out_count_a", {24'd0, out_count_a}, 32'(exp_a));
    check("out_count_b", {30'd0, out_count_b}, 32'(exp_b));
    check("out_zero_a", {31'd0, out_zero_a}, {31'd0, exp_d == '0});
    check("out_zero_b", {31'd0, out_zero_b}, {31'd0, exp_d == '0});
    for (int k = 0; k < bp; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      in_data   = W'($urandom);
      in_last   = 1'($urandom);
      op        = 2'($urandom);
      tick();
      check("bp_valid", {31'd0, out_valid_a}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
      check("bp_data", {16'd0, out_data_a}, {16'd0, exp_d});
      check("bp_count", {24'd0, out_count_a}, 32'(exp_a));
      check("bp_count_b", {30'd0, out_count_b}, 32'(exp_b));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_valid", {31'd0, out_valid_a}, 32'd0);
    check("post_hs_ready", {31'd0, in_ready_a}, 32'd1);
    check("post_hs_ready_b", {31'd0, in_ready_b}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; op = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_out_data", {16'd0, out_data_a}, 32'd0);
    check("rst_out_count", {24'd0, out_count_a}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero_a}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // AND over three words
    words[0] = 16'hFFFF; words[1] = 16'h0F0F; words[2] = 16'h00FF;
    run_frame(3, 2'd0, 0, 1'b0);
    // NAND two words, then single-word NAND to zero
    words[0] = 16'hAAAA; words[1] = 16'hAAAA;
    run_frame(2, 2'd3, 0, 1'b0);
    words[0] = 16'hFFFF;
    run_frame(1, 2'd3, 0, 1'b0);
    // XOR to zero, op port toggled mid-frame by run_frame
    words[0] = 16'h1234; words[1] = 16'h1234;
    run_frame(2, 2'd2, 0, 1'b0);
    // Backpressure for 5 cycles
    words[0] = 16'h8001; words[1] = 16'hC003; words[2] = 16'hF00F;
    run_frame(3, 2'd1, 5, 1'b0);
    // Six-word OR: saturates the 2-bit counter
    for (int i = 0; i < 6; i++) words[i] = W'(16'h1 << (i * 2));
    run_frame(6, 2'd1, 0, 1'b1);

    // Reset after 2 of 4 words
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); in_last = 1'b0; op = 2'd0;
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("midrst_out_count", {24'd0, out_count_a}, 32'd0);
    check("midrst_out_count_b", {30'd0, out_count_b}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    words[0] = 16'h00F0;
    run_frame(1, 2'd1, 0, 1'b0);

    // Random frames
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) words[i] = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 1; i < n; i++) words[i] = words[0];
      end
      run_frame(n, 2'($urandom), $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
